// File: rtl/mul_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mul_hilo_ctrl
//  Purpose  : Iterative shift-add multiply / multiply-accumulate sequencer
//             that owns the HI/LO register pair and services mthi/mtlo.
//  Revision : 1.0  - initial release
// ============================================================================
module mul_hilo_ctrl #(
    parameter int BITS_PER_CYCLE = 1    // 1, 2, 4 or 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] hilo_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int         c_ITERS = 32 / BITS_PER_CYCLE;
    localparam logic [5:0] c_LAST  = 6'(c_ITERS - 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MULT = 2'd1;
    localparam logic [1:0] c_ST_ACC  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [1:0] c_OP_MUL   = 2'b00;
    localparam logic [1:0] c_OP_MADD  = 2'b01;
    localparam logic [1:0] c_OP_MADDU = 2'b10;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [5:0]  r_cnt;
    logic [63:0] r_mcand;     // multiplicand, pre-shifted to the current weight
    logic [31:0] r_mplier;    // multiplier, consumed from the bottom
    logic        r_neg;
    logic [1:0]  r_op;
    logic [63:0] r_prod;

    logic        w_signed_op;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [63:0] w_step;
    logic [63:0] w_p;
    logic        w_accum;

    // Magnitudes for signed ops; 0x80000000 maps to itself, read as 2^31.
    assign w_signed_op = (op == c_OP_MUL) || (op == c_OP_MADD);
    assign w_a_mag     = (w_signed_op && a[31]) ? (~a + 32'd1) : a;
    assign w_b_mag     = (w_signed_op && b[31]) ? (~b + 32'd1) : b;

    assign w_accum = (r_op == c_OP_MADD) || (r_op == c_OP_MADDU);
    assign w_p     = r_neg ? (~r_prod + 64'd1) : r_prod;

    assign busy = (r_state != c_ST_IDLE);
    assign done = (r_state == c_ST_DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Partial product contributed by the low multiplier bits this cycle.
    always_comb begin
        w_step = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_mplier[i]) begin
                w_step = w_step + (r_mcand << i);
            end
        end
    end

    // Next-state logic for the sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_nxt = c_ST_MULT;
            c_ST_MULT: if (r_cnt == c_LAST) w_state_nxt = c_ST_ACC;
            c_ST_ACC:  w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, iteration datapath and HI/LO updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_op     <= '0;
            r_prod   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // A start takes precedence over a same-cycle HI/LO write.
                    if (start) begin
                        r_mcand  <= {32'd0, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= w_signed_op & (a[31] ^ b[31]);
                        r_op     <= op;
                        r_prod   <= '0;
                        r_cnt    <= '0;
                    end else if (hilo_we) begin
                        if (hilo_sel) begin
                            r_hi <= hilo_wdata;
                        end else begin
                            r_lo <= hilo_wdata;
                        end
                    end
                end
                c_ST_MULT: begin
                    r_prod   <= r_prod + w_step;
                    r_mcand  <= r_mcand << BITS_PER_CYCLE;
                    r_mplier <= r_mplier >> BITS_PER_CYCLE;
                    r_cnt    <= r_cnt + 6'd1;
                end
                c_ST_ACC: begin
                    if (w_accum) begin
                        {r_hi, r_lo} <= {r_hi, r_lo} + w_p;
                    end else begin
                        {r_hi, r_lo} <= w_p;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
